// File: rtl/sha1_step_ctrl.sv
// sha1_step_ctrl: round sequencer for the SHA-1 core.
//
// Samples the divided clock (tick_clk) as data and synchronizes it into the
// sys_clk domain. It turns each rising edge into a one-cycle round step, and
// produces the load strobe, round index and round-function select that the
// hash datapath consumes.
//
// Ports:
//   sys_clk    in   system clock, the only clock in the block
//   sys_rst    in   synchronous active-low reset
//   tick_clk   in   divided clock, asynchronous, treated as data
//   start      in   request to hash one block
//   abort      in   cancel the block in progress
//   load       out  one-cycle strobe: load message block and H0..H4
//   round_en   out  one-cycle strobe: execute round round_idx
//   round_idx  out  current round number
//   f_sel      out  round-function group decoded from round_idx
//   busy       out  high while loading or running
//   done       out  high once all rounds have been stepped
module sha1_step_ctrl #(
   parameter int unsigned ROUNDS      = 80,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       tick_clk,
   input  logic       start,
   input  logic       abort,
   output logic       load,
   output logic       round_en,
   output logic [6:0] round_idx,
   output logic [1:0] f_sel,
   output logic       busy,
   output logic       done
);

   localparam int unsigned IDX_W     = 7;
   localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
   localparam int unsigned PRIME_W   = $clog2(PRIME_MAX + 1);

   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(ROUNDS - 1);
   localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_MAX);

   localparam logic [IDX_W-1:0] GRP1_START = IDX_W'(20);
   localparam logic [IDX_W-1:0] GRP2_START = IDX_W'(40);
   localparam logic [IDX_W-1:0] GRP3_START = IDX_W'(60);

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("sha1_step_ctrl: SYNC_STAGES must be at least 2");
      end
      if (ROUNDS < 1 || ROUNDS > 128) begin : g_bad_rounds
         $error("sha1_step_ctrl: ROUNDS must fit the 7-bit round index");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic [PRIME_W-1:0]     prime_q;
   logic                   primed;
   logic                   tick;

   // Synchronizer chain, edge-detect history flop and post-reset prime counter.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         sync_q  <= '0;
         hist_q  <= 1'b0;
         prime_q <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], tick_clk};
         hist_q  <= sync_q[SYNC_STAGES-1];
         if (prime_q != PRIME_DONE) begin
            prime_q <= prime_q + PRIME_W'(1);
         end
      end
   end

   // Edges are ignored until the chain has refilled after reset, so a
   // tick_clk that is already high at release is not seen as a rising edge.
   assign primed = (prime_q == PRIME_DONE);
   assign tick   = sync_q[SYNC_STAGES-1] & ~hist_q & primed;

   // Sequencer with registered strobes and status.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         state     <= ST_IDLE;
         load      <= 1'b0;
         round_en  <= 1'b0;
         round_idx <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         load     <= 1'b0;
         round_en <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state     <= ST_LOAD;
                  load      <= 1'b1;
                  round_idx <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            ST_LOAD: begin
               // Ticks landing in the load cycle are dropped.
               if (abort) begin
                  state     <= ST_IDLE;
                  round_idx <= '0;
                  busy      <= 1'b0;
               end else begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state     <= ST_IDLE;
                  round_idx <= '0;
                  busy      <= 1'b0;
               end else if (round_en) begin
                  // Advance the index only after the datapath has used it.
                  if (round_idx == LAST_IDX) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     round_idx <= round_idx + IDX_W'(1);
                  end
               end else if (tick) begin
                  round_en <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               round_idx <= '0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

   // Round-function group, decoded from the registered index.
   always_comb begin
      f_sel = 2'd3;
      if (round_idx < GRP1_START) begin
         f_sel = 2'd0;
      end else if (round_idx < GRP2_START) begin
         f_sel = 2'd1;
      end else if (round_idx < GRP3_START) begin
         f_sel = 2'd2;
      end
   end

endmodule

// File: tb/tb_sha1_step_ctrl.sv
// Testbench for sha1_step_ctrl: scenario tasks plus a randomized run, all
// checked against a cycle-level reference model of the sequencing rules.
module tb_sha1_step_ctrl;

   localparam int ROUNDS      = 80;
   localparam int SYNC_STAGES = 2;
   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_RUN  = 2;
   localparam int P_DONE = 3;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b0;
   logic       tick_clk = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       load;
   logic       round_en;
   logic [6:0] round_idx;
   logic [1:0] f_sel;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   sha1_step_ctrl #(.ROUNDS(ROUNDS), .SYNC_STAGES(SYNC_STAGES)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .tick_clk  (tick_clk),
      .start     (start),
      .abort     (abort),
      .load      (load),
      .round_en  (round_en),
      .round_idx (round_idx),
      .f_sel     (f_sel),
      .busy      (busy),
      .done      (done)
   );

   always #5 sys_clk = ~sys_clk;

   // tick_clk source: free-running square wave or a held level.
   bit tick_run  = 1'b0;
   bit tick_hold = 1'b0;
   int tick_half = 4;
   int tick_cnt  = 0;
   always @(negedge sys_clk) begin
      #1;
      if (!tick_run) begin
         tick_clk = tick_hold;
         tick_cnt = 0;
      end else begin
         tick_cnt++;
         if (tick_cnt >= tick_half) begin
            tick_clk = ~tick_clk;
            tick_cnt = 0;
         end
      end
   end

   // Reference model: sampled tick_clk history, rounds counted as plain integers.
   bit [15:0] m_sh    = '0;
   int        m_edges = 0;
   int        m_ph    = P_IDLE;
   int        m_idx   = 0;
   bit        m_load  = 1'b0;
   bit        m_ren   = 1'b0;
   bit        m_tick;
   bit        mt, ld_nx, re_nx;

   assign m_tick = (m_edges >= SYNC_STAGES + 1) && m_sh[SYNC_STAGES-1] && !m_sh[SYNC_STAGES];

   always @(posedge sys_clk) begin
      cyc++;
      mt = (m_edges >= SYNC_STAGES + 1) && m_sh[SYNC_STAGES-1] && !m_sh[SYNC_STAGES];
      if (!sys_rst) begin
         m_ph = P_IDLE; m_idx = 0; m_load = 0; m_ren = 0; m_sh = '0; m_edges = 0;
      end else begin
         ld_nx = 0;
         re_nx = 0;
         if (m_ph == P_IDLE || m_ph == P_DONE) begin
            if (start) begin m_ph = P_LOAD; m_idx = 0; ld_nx = 1; end
         end else if (m_ph == P_LOAD) begin
            m_ph = abort ? P_IDLE : P_RUN;
         end else begin
            if (abort) begin
               m_ph = P_IDLE; m_idx = 0;
            end else if (m_ren) begin
               if (m_idx == ROUNDS - 1) m_ph = P_DONE;
               else m_idx = m_idx + 1;
            end else if (mt) begin
               re_nx = 1;
            end
         end
         m_load = ld_nx;
         m_ren  = re_nx;
         m_sh   = {m_sh[14:0], tick_clk};
         if (m_edges < 1000) m_edges++;
      end
   end

   logic [12:0] dut_vec, exp_vec;
   assign dut_vec = {load, round_en, round_idx, f_sel, busy, done};
   assign exp_vec = {m_load, m_ren, 7'(m_idx), 2'(m_idx / 20),
                     (m_ph == P_LOAD) || (m_ph == P_RUN), m_ph == P_DONE};

   task automatic test_reset();
      int seen = 0;
      tick_run = 0; tick_hold = 1; sys_rst = 0; start = 0; abort = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk);
         n_checks++;
         if (dut_vec !== 13'd0) begin n_fail++; $display("FAIL reset_outputs cyc=%0d got=%h want=0", cyc, dut_vec); end
      end
      sys_rst = 1; start = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge sys_clk);
         start = 0;
         n_checks++;
         if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL prime_vec cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
         n_checks++;
         if (round_en !== 1'b0) begin n_fail++; $display("FAIL prime_no_step cyc=%0d got=%b want=0", cyc, round_en); end
      end
      tick_hold = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge sys_clk);
         n_checks++;
         if (round_en !== 1'b0) begin n_fail++; $display("FAIL prime_low_no_step cyc=%0d got=%b want=0", cyc, round_en); end
      end
      tick_hold = 1;
      for (int i = 0; i < SYNC_STAGES + 4; i++) begin
         @(negedge sys_clk);
         if (round_en === 1'b1) seen++;
         n_checks++;
         if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL prime_edge_vec cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
      end
      n_checks++;
      if (seen != 1) begin n_fail++; $display("FAIL prime_first_step got=%0d want=1", seen); end
      abort = 1;
      @(negedge sys_clk);
      abort = 0;
      n_checks++;
      if (busy !== 1'b0 || round_idx !== 7'd0) begin n_fail++; $display("FAIL reset_abort_idle busy=%b idx=%0d want 0/0", busy, round_idx); end
   endtask

   task automatic test_full_block();
      int ren_idx[$];
      int ren_cyc[$];
      int ren_fs[$];
      int loads = 0;
      bit fin = 0;
      tick_run = 1; tick_half = 4;
      @(negedge sys_clk);
      start = 1;
      for (int i = 0; i < 1200 && !fin; i++) begin
         @(negedge sys_clk);
         start = 0;
         n_checks++;
         if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL full_vec cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
         if (load === 1'b1) loads++;
         if (round_en === 1'b1) begin
            ren_idx.push_back(int'(round_idx));
            ren_cyc.push_back(cyc);
            ren_fs.push_back(int'(f_sel));
         end
         if (done === 1'b1) fin = 1;
      end
      n_checks++;
      if (!fin) begin n_fail++; $display("FAIL full_timeout done=%b want=1", done); end
      n_checks++;
      if (loads != 1) begin n_fail++; $display("FAIL full_loads got=%0d want=1", loads); end
      n_checks++;
      if (ren_idx.size() != ROUNDS) begin n_fail++; $display("FAIL full_count got=%0d want=%0d", ren_idx.size(), ROUNDS); end
      for (int i = 0; i < ren_idx.size(); i++) begin
         n_checks++;
         if (ren_idx[i] != i) begin n_fail++; $display("FAIL full_order n=%0d got=%0d want=%0d", i, ren_idx[i], i); end
         n_checks++;
         if (ren_fs[i] != i / 20) begin n_fail++; $display("FAIL full_fsel n=%0d got=%0d want=%0d", i, ren_fs[i], i / 20); end
         if (i > 0) begin
            n_checks++;
            if (ren_cyc[i] - ren_cyc[i-1] != 8) begin n_fail++; $display("FAIL full_spacing n=%0d got=%0d want=8", i, ren_cyc[i] - ren_cyc[i-1]); end
         end
      end
   endtask

   task automatic test_latency();
      tick_run = 0; tick_hold = 0;
      start = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge sys_clk);
         start = 0;
         n_checks++;
         if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL lat_setup_vec cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
      end
      tick_hold = 1;
      for (int i = 1; i <= SYNC_STAGES + 2; i++) begin
         @(negedge sys_clk);
         n_checks++;
         if (round_en !== (i == SYNC_STAGES + 1)) begin n_fail++; $display("FAIL lat_round_en k=%0d got=%b want=%b", i, round_en, i == SYNC_STAGES + 1); end
         n_checks++;
         if (round_idx !== ((i == SYNC_STAGES + 2) ? 7'd1 : 7'd0)) begin n_fail++; $display("FAIL lat_idx k=%0d got=%0d", i, round_idx); end
      end
   endtask

   task automatic test_abort();
      bit hit = 0;
      tick_run = 1; tick_half = 4;
      for (int i = 0; i < 2000 && !hit; i++) begin
         @(negedge sys_clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL abort_run_vec cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
         if (m_ph == P_RUN && m_tick && !m_ren && m_idx == 37) begin
            abort = 1;
            hit = 1;
         end
      end
      n_checks++;
      if (!hit) begin n_fail++; $display("FAIL abort_timeout idx=%0d want 37", round_idx); end
      @(negedge sys_clk);
      abort = 0;
      n_checks++;
      if (round_en !== 1'b0 || round_idx !== 7'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL abort_idle en=%b idx=%0d busy=%b want 0/0/0", round_en, round_idx, busy);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge sys_clk);
         n_checks++;
         if (round_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_quiet cyc=%0d en=%b busy=%b want 0/0", cyc, round_en, busy); end
      end
   endtask

   task automatic test_restart();
      bit hit = 0;
      int cnt = 0;
      tick_run = 1; tick_half = 4;
      start = 1;
      for (int i = 0; i < 500 && !hit; i++) begin
         @(negedge sys_clk);
         start = 0;
         if (m_ph == P_RUN && m_idx == 10) hit = 1;
      end
      start = 1;
      @(negedge sys_clk);
      start = 0;
      n_checks++;
      if (load !== 1'b0 || busy !== 1'b1 || !hit) begin n_fail++; $display("FAIL restart_ignore load=%b busy=%b want 0/1", load, busy); end
      hit = 0;
      for (int i = 0; i < 1000 && !hit; i++) begin
         @(negedge sys_clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL restart_vec cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
         if (done === 1'b1) hit = 1;
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         n_checks++;
         if (done !== 1'b1 || round_en !== 1'b0 || round_idx !== 7'd79) begin
            n_fail++; $display("FAIL done_hold done=%b en=%b idx=%0d want 1/0/79", done, round_en, round_idx);
         end
      end
      start = 1;
      @(negedge sys_clk);
      start = 0;
      n_checks++;
      if (load !== 1'b1 || done !== 1'b0 || round_idx !== 7'd0) begin
         n_fail++; $display("FAIL done_restart load=%b done=%b idx=%0d want 1/0/0", load, done, round_idx);
      end
      hit = 0;
      for (int i = 0; i < 1000 && !hit; i++) begin
         @(negedge sys_clk);
         if (round_en === 1'b1) begin
            n_checks++;
            if (int'(round_idx) != cnt) begin n_fail++; $display("FAIL restart_order got=%0d want=%0d", round_idx, cnt); end
            cnt++;
         end
         if (done === 1'b1) hit = 1;
      end
      n_checks++;
      if (cnt != ROUNDS) begin n_fail++; $display("FAIL restart_count got=%0d want=%0d", cnt, ROUNDS); end
   endtask

   task automatic test_reset_mid();
      bit hit = 0;
      tick_run = 1; tick_half = 4;
      start = 1;
      for (int i = 0; i < 1000 && !hit; i++) begin
         @(negedge sys_clk);
         start = 0;
         if (m_ren && m_idx == 50) begin
            sys_rst = 0;
            hit = 1;
         end
      end
      @(negedge sys_clk);
      sys_rst = 1;
      n_checks++;
      if (dut_vec !== 13'd0 || !hit) begin n_fail++; $display("FAIL midreset_outputs got=%h want=0", dut_vec); end
      for (int i = 0; i < 60; i++) begin
         @(negedge sys_clk);
         n_checks++;
         if (round_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet cyc=%0d en=%b busy=%b want 0/0", cyc, round_en, busy); end
      end
   endtask

   task automatic test_random();
      tick_run = 1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge sys_clk);
         n_checks++;
         if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL random_vec cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec); end
         if (i % 400 == 0) tick_half = int'($urandom_range(7, 3));
         start   = ($urandom % 20) == 0;
         abort   = ($urandom % 60) == 0;
         sys_rst = ($urandom % 700) != 0;
      end
      start = 0; abort = 0; sys_rst = 1;
   endtask

   initial begin
      test_reset();
      test_full_block();
      test_latency();
      test_abort();
      test_restart();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d limit reached", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sha1_step_ctrl.md
# sha1_step_ctrl

Round sequencer for the SHA-1 core, directly downstream of the clock divider. Takes the divider's slow output `clk1` as a plain data signal (`tick_clk`) and synchronizes it into the `sys_clk` domain. It turns each rising edge into a one-cycle step enable, so the 80 SHA-1 rounds advance at a human-visible rate on the board. It also generates the load strobe, round index and round-function select that the hash datapath consumes.

## Interface
Parameters:
- `ROUNDS`, 80: rounds per block; `round_idx` counts 0..ROUNDS-1.
- `SYNC_STAGES`, 2: flip-flops in the `tick_clk` synchronizer; minimum 2.

Ports:
- `sys_clk`  in  1  system clock; only clock in the block.
- `sys_rst`  in  1  reset, synchronous, active-low (0 = reset, sampled on `sys_clk` rising edge).
- `tick_clk`  in  1  divided clock from the clock divider (`clk1`); asynchronous to the block's logic, treated as data.
- `start`  in  1  request to hash one block; sampled every cycle.
- `abort`  in  1  cancel the current block; sampled every cycle.
- `load`  out  1  one-cycle strobe: datapath loads the message block and initial H0..H4.
- `round_en`  out  1  one-cycle strobe: datapath executes round `round_idx`.
- `round_idx`  out  7  current round number, 0..79.
- `f_sel`  out  2  round-function group: 0 for rounds 0-19, 1 for 20-39, 2 for 40-59, 3 for 60-79.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  high in DONE.

## Operation
- Synchronizer: `SYNC_STAGES` flops, then one history flop. Internal `tick` is high when the synchronized value is 1 and the history value is 0.
- Prime guard: after reset, `tick` is suppressed for the first `SYNC_STAGES+1` cycles. This prevents a false edge when `tick_clk` is already high at reset release.
- States:
  - IDLE (reset state):
    - `start`=1 -> LOAD.
  - LOAD:
    - `load`=1 for exactly this cycle; `round_idx`=0.
    - Next state is always RUN (unless `abort`).
  - RUN:
    - On each `tick`: `round_en`=1 for one cycle, with `round_idx` equal to the round being executed.
    - Cycle after a `round_en`: `round_idx` increments.
    - If the pulsed round was ROUNDS-1: state -> DONE and `round_idx` holds at ROUNDS-1.
  - DONE:
    - `done`=1; outputs hold.
    - `start`=1 -> LOAD; otherwise stays in DONE.
- `f_sel` is combinational from `round_idx`: `round_idx` < 20 -> 0, < 40 -> 1, < 60 -> 2, else 3.
- Ticks outside RUN are dropped, not queued. A tick in the LOAD cycle does not produce `round_en`.
- `start` is ignored in LOAD and RUN.
- `abort`:
  - `abort`=1 in LOAD or RUN -> IDLE on the next edge; `round_idx` -> 0.
  - No `round_en` is produced in that cycle.
  - `abort` has priority over a simultaneous `tick` or `start`.
  - `abort` in IDLE or DONE has no effect.
- Reset (`sys_rst`=0), regardless of state:
  - State -> IDLE.
  - All outputs 0, `round_idx`=0.
  - Synchronizer, history flop and prime counter cleared.
  - Any block in progress is lost.

## Timing
- Reset values: `load`=0, `round_en`=0, `round_idx`=0, `f_sel`=0, `busy`=0, `done`=0.
- All outputs are registered except `f_sel`, which is decoded from registered `round_idx`.
- `start` sampled high in IDLE at edge N: `load`=1 and `busy`=1 during cycle N+1; RUN from N+2.
- `tick_clk` latency:
  - `tick_clk` first sampled high at edge N -> `tick` during cycle N+SYNC_STAGES.
  - -> `round_en` during cycle N+SYNC_STAGES+1.
  - Worst case, `tick_clk` rising to `round_en`: SYNC_STAGES+2 `sys_clk` cycles.
- Tick rate: one `round_en` per `tick_clk` period. `tick_clk` high and low phases must each be ≥ SYNC_STAGES+1 `sys_clk` cycles; narrower pulses may be missed.
- Final round:
  - `round_en` with `round_idx`=79 in cycle M.
  - `busy`=0 and `done`=1 from cycle M+1.
- `done`=1 and `start` at edge K -> `done`=0, `load`=1 during cycle K+1.

## Test plan
- Reset and prime:
  - Hold `sys_rst`=0 for 4 cycles with `tick_clk`=1, release it, pulse `start` immediately.
  - -> no `round_en` until `tick_clk` goes 0 and then 1 again; all outputs 0 during reset.
- Full block:
  - `div1`-equivalent stimulus: `tick_clk` with period 8 `sys_clk` cycles; pulse `start`.
  - -> one `load`, then exactly 80 `round_en` pulses with `round_idx` 0..79 in order, 8 cycles apart.
  - -> `f_sel` changes at 20/40/60; `done`=1 after idx 79.
- Latency:
  - `tick_clk` rising aligned just before a `sys_clk` edge, in RUN.
  - -> `round_en` exactly SYNC_STAGES+1 cycles after that edge; `round_idx` increments the following cycle.
- Abort:
  - `abort` asserted in the same cycle as the `tick` for round 37.
  - -> no `round_en` for 37; IDLE next cycle with `round_idx`=0, `busy`=0.
  - -> further ticks produce nothing.
- Restart and ignore:
  - Pulse `start` mid-RUN -> ignored.
  - Pulse `start` in DONE -> `load` next cycle and a fresh 80-round sequence from `round_idx`=0.
- Reset mid-operation:
  - `sys_rst`=0 at round 50 -> all outputs 0 next cycle and state IDLE.
  - After release, no `round_en` until a new `start`.
